// File: rtl/fpmul_pkg.sv
// Shared types and constants for the sequential binary32 multiply unit (fpmul_seq).
// FPMUL_SPECIAL_EN enables zero/Inf/NaN bypass and ovf/unf saturation.
package fpmul_pkg;

    localparam int EXP_W   = 8;
    localparam int FRAC_W  = 23;
    localparam int FP_BIAS = 127;
    localparam logic signed [9:0] FP_BIAS10 = 10'(FP_BIAS);
    localparam logic [31:0] FP_QNAN = 32'h7FC0_0000;

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_ARM,
        S_WAIT,
        S_NORM,
        S_OUT
    } state_e;

    typedef enum logic [1:0] {
        SP_NONE,
        SP_NAN,
        SP_INF,
        SP_ZERO
    } spec_e;

    // Denormals classify as zero; 0 x Inf is an invalid operation.
    function automatic spec_e fp_classify(input logic [31:0] a, input logic [31:0] b);
        logic a_nan, a_inf, a_zero, b_nan, b_inf, b_zero;
        a_nan  = (&a[30:23]) && (|a[22:0]);
        a_inf  = (&a[30:23]) && !(|a[22:0]);
        a_zero = !(|a[30:23]);
        b_nan  = (&b[30:23]) && (|b[22:0]);
        b_inf  = (&b[30:23]) && !(|b[22:0]);
        b_zero = !(|b[30:23]);
        if (a_nan || b_nan || (a_zero && b_inf) || (a_inf && b_zero))
            return SP_NAN;
        else if (a_inf || b_inf)
            return SP_INF;
        else if (a_zero || b_zero)
            return SP_ZERO;
        else
            return SP_NONE;
    endfunction

endpackage

// File: rtl/fpmul_pack.sv
// Combinational normalize/pack stage: 25-bit mantissa product -> binary32 with ovf/unf.
// With FPMUL_SPECIAL_EN, also applies special-operand results and saturation.
module fpmul_pack
    import fpmul_pkg::*;
(
    input  logic                i_sign,
    input  logic signed [9:0]   i_exp,
    input  logic [24:0]         i_prod,
`ifdef FPMUL_SPECIAL_EN
    input  spec_e               i_special,
`endif
    output logic [31:0]         o_z,
    output logic                o_ovf,
    output logic                o_unf
);

    logic signed [9:0]   w_exp;
    logic [FRAC_W-1:0]   w_frac;
    logic                w_ovf;
    logic                w_unf;

    // A product in [2,4) shifts right by one and bumps the exponent; rounding is truncation.
    assign w_exp  = i_exp + $signed({9'b0, i_prod[24]});
    assign w_frac = i_prod[24] ? i_prod[23:1] : i_prod[22:0];
    assign w_ovf  = (w_exp >= 10'sd255);
    assign w_unf  = (w_exp <= 10'sd0);

    always_comb begin
        o_ovf = w_ovf;
        o_unf = w_unf;
        o_z   = {i_sign, w_exp[EXP_W-1:0], w_frac};
`ifdef FPMUL_SPECIAL_EN
        if (w_ovf)
            o_z = {i_sign, 8'hFF, 23'b0};
        else if (w_unf)
            o_z = {i_sign, 31'b0};
        case (i_special)
            SP_NAN:  begin o_z = FP_QNAN;                 o_ovf = 1'b0; o_unf = 1'b0; end
            SP_INF:  begin o_z = {i_sign, 8'hFF, 23'b0}; o_ovf = 1'b0; o_unf = 1'b0; end
            SP_ZERO: begin o_z = {i_sign, 31'b0};         o_ovf = 1'b0; o_unf = 1'b0; end
            default: ;
        endcase
`endif
    end

endmodule

// File: rtl/fpmul_seq.sv
// Sequencing controller wrapping one seqmult instance into a binary32 multiplier.
// FPMUL_SPECIAL_EN: zero/Inf/NaN operands skip the multiplier and results saturate.
module fpmul_seq
    import fpmul_pkg::*;
#(
    parameter int MUL_TIMEOUT = 64
)(
    input  logic                i_clk,
    input  logic                i_rst_n,
    input  logic                i_in_valid,
    output logic                o_in_ready,
    input  logic [31:0]         i_a,
    input  logic [31:0]         i_b,
    output logic                o_out_valid,
    input  logic                i_out_ready,
    output logic [31:0]         o_z,
    output logic                o_ovf,
    output logic                o_unf,
    output logic                o_err,
    output logic                o_mul_start,
    output logic [FRAC_W-1:0]   o_mul_a,
    output logic [FRAC_W-1:0]   o_mul_b,
    input  logic [24:0]         i_mul_result,
    input  logic                i_mul_done
);

    localparam int CNT_W = $clog2(MUL_TIMEOUT + 2);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MUL_TIMEOUT);

    state_e              r_state, w_state_next;
    logic                r_sign;
    logic signed [9:0]   r_exp;
    logic [24:0]         r_prod;
    logic [FRAC_W-1:0]   r_mul_a, r_mul_b;
    logic [CNT_W-1:0]    r_cnt;
    logic [31:0]         r_z;
    logic                r_ovf, r_unf, r_err;

    logic                w_in_ready, w_out_valid, w_mul_start, w_timeout, w_accept;
    logic signed [9:0]   w_exp_sum;
    logic [31:0]         w_pack_z;
    logic                w_pack_ovf, w_pack_unf;
`ifdef FPMUL_SPECIAL_EN
    spec_e               r_special, w_special;
    assign w_special = fp_classify(i_a, i_b);
`endif

    assign w_exp_sum = $signed({2'b00, i_a[30:23]}) + $signed({2'b00, i_b[30:23]}) - FP_BIAS10;
    assign w_accept  = (r_state == S_IDLE) && i_in_valid;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n)
            r_state <= S_IDLE;
        else
            r_state <= w_state_next;
    end

    always_comb begin
        w_state_next = r_state;
        w_in_ready   = 1'b0;
        w_out_valid  = 1'b0;
        w_mul_start  = 1'b0;
        w_timeout    = 1'b0;
        case (r_state)
            S_IDLE: begin
                w_in_ready = 1'b1;
                if (i_in_valid) begin
`ifdef FPMUL_SPECIAL_EN
                    w_state_next = (w_special != SP_NONE) ? S_NORM : S_START;
`else
                    w_state_next = S_START;
`endif
                end
            end
            S_START: begin
                w_mul_start  = 1'b1;
                w_state_next = S_ARM;
            end
            S_ARM: begin
                if (r_cnt == CNT_MAX) begin
                    w_timeout    = 1'b1;
                    w_state_next = S_OUT;
                end else if (!i_mul_done) begin
                    w_state_next = S_WAIT;
                end
            end
            S_WAIT: begin
                if (r_cnt == CNT_MAX) begin
                    w_timeout    = 1'b1;
                    w_state_next = S_OUT;
                end else if (i_mul_done) begin
                    w_state_next = S_NORM;
                end
            end
            S_NORM: w_state_next = S_OUT;
            S_OUT: begin
                w_out_valid = 1'b1;
                if (i_out_ready)
                    w_state_next = S_IDLE;
            end
            default: w_state_next = S_IDLE;
        endcase
    end

    fpmul_pack u_pack (
        .i_sign    (r_sign),
        .i_exp     (r_exp),
        .i_prod    (r_prod),
`ifdef FPMUL_SPECIAL_EN
        .i_special (r_special),
`endif
        .o_z       (w_pack_z),
        .o_ovf     (w_pack_ovf),
        .o_unf     (w_pack_unf)
    );

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_sign    <= 1'b0;
            r_exp     <= '0;
            r_prod    <= '0;
            r_mul_a   <= '0;
            r_mul_b   <= '0;
            r_cnt     <= '0;
            r_z       <= '0;
            r_ovf     <= 1'b0;
            r_unf     <= 1'b0;
            r_err     <= 1'b0;
`ifdef FPMUL_SPECIAL_EN
            r_special <= SP_NONE;
`endif
        end else begin
            if (w_accept) begin
                r_sign    <= i_a[31] ^ i_b[31];
                r_exp     <= w_exp_sum;
                r_mul_a   <= i_a[FRAC_W-1:0];
                r_mul_b   <= i_b[FRAC_W-1:0];
`ifdef FPMUL_SPECIAL_EN
                r_special <= w_special;
`endif
            end
            if (r_state == S_START)
                r_cnt <= '0;
            else if ((r_state == S_ARM) || (r_state == S_WAIT))
                r_cnt <= r_cnt + CNT_W'(1);
            if ((r_state == S_WAIT) && i_mul_done)
                r_prod <= i_mul_result;
            // Result and flags only move on entry to OUT, so they stay put under back-pressure.
            if (w_timeout) begin
                r_z   <= FP_QNAN;
                r_ovf <= 1'b0;
                r_unf <= 1'b0;
                r_err <= 1'b1;
            end else if (r_state == S_NORM) begin
                r_z   <= w_pack_z;
                r_ovf <= w_pack_ovf;
                r_unf <= w_pack_unf;
                r_err <= 1'b0;
            end
        end
    end

    assign o_in_ready  = w_in_ready & i_rst_n;
    assign o_out_valid = w_out_valid;
    assign o_mul_start = w_mul_start;
    assign o_mul_a     = r_mul_a;
    assign o_mul_b     = r_mul_b;
    assign o_z         = r_z;
    assign o_ovf       = r_ovf;
    assign o_unf       = r_unf;
    assign o_err       = r_err;

endmodule

// File: doc/fpmul_seq.md
# fpmul_seq

Sequencing controller that turns the shared 23-bit sequential mantissa multiplier (`seqmult`) into a complete IEEE 754 binary32 multiply unit. It accepts operand pairs over a valid/ready handshake and computes sign and exponent itself. It drives the multiplier's start/done handshake, normalizes and packs the 25-bit mantissa product, and returns the result over a second valid/ready handshake. It sits between the FP issue logic and one `seqmult` instance.

## Interface
- `MUL_TIMEOUT`, default 64: max cycles to wait for the multiplier to finish before flagging an error.
- `clk` in 1: clock; all state on posedge.
- `rst_n` in 1: one clock; reset is asynchronous and active-low.
- `in_valid` in 1: operand pair valid.
- `in_ready` out 1: controller can accept an operand pair; high only in IDLE.
- `a`, `b` in 32: binary32 operands.
- `out_valid` out 1: result valid.
- `out_ready` in 1: consumer accepts the result.
- `z` out 32: binary32 product.
- `ovf`, `unf`, `err` out 1: exponent overflow, exponent underflow, multiplier timeout.
- `mul_start` out 1: to `seqmult.startMul`.
- `mul_a`, `mul_b` out 23: fraction fields, to `seqmult.A/B`.
- `mul_result` in 25: `seqmult.result`.
- `mul_done` in 1: `seqmult.doneMul`, high while the multiplier is idle.

## Operation
- States:
  - IDLE: in_ready=1.
  - START: mul_start=1 for exactly 1 cycle.
  - ARM: mul_start=0; wait for mul_done=0.
  - WAIT: wait for mul_done=1.
  - NORM: normalize, round, pack.
  - OUT: out_valid=1 until out_ready.
- Transitions:
  - IDLE→START on in_valid. The operands, sign `sa^sb` and biased exponent sum `ea+eb-127` (10-bit signed) are registered.
  - START→ARM unconditionally.
  - ARM→WAIT when mul_done=0.
  - WAIT→NORM when mul_done=1.
  - NORM→OUT.
  - OUT→IDLE when out_ready.
- mul_a/mul_b are held from the accept until leaving WAIT.
- Normalize:
  - If mul_result[24]=1: fraction=mul_result[23:1], exponent+1.
  - Otherwise: fraction=mul_result[22:0].
  - Rounding is truncation.
- Final exponent e:
  - e≥255: ovf=1.
  - e≤0: unf=1.
  - Field = e[7:0] unless overridden by SPECIAL handling (see Configuration).
- Timeout: one cycle counter is cleared on entry to ARM and increments in ARM/WAIT. When it reaches MUL_TIMEOUT: go to OUT with err=1, z=0x7FC00000.
- Flags and z are registered and change only on entry to OUT.

## Timing
- Reset values: in_ready=0 while rst_n low, then 1 (IDLE); out_valid=0, z=0, ovf=unf=err=0, mul_start=0, mul_a=mul_b=0. Counter=0.
- Latency from accept to out_valid = 4 + T, where T = cycles from mul_start fall to mul_done rise.
- Back-pressure: z and flags are stable while out_valid && !out_ready. No new accept until the result is consumed.
- in_valid during a busy period is ignored, not queued.
- rst_n low mid-operation aborts immediately to IDLE. Any held result is discarded, and mul_start is deasserted asynchronously.

## Configuration
- `FPMUL_SPECIAL_EN` defined:
  - Zero, Inf and NaN operands bypass the multiplier: IDLE→NORM directly, no mul_start pulse.
    - NaN in either operand, or 0×Inf: z=0x7FC00000.
    - Inf: z = ±Inf.
    - Zero: z = ±0.
  - Denormal inputs are treated as zero.
  - ovf saturates z to ±Inf; unf flushes z to ±0.
- Undefined: all operands take the multiplier path as normal numbers, and the exponent field wraps (e[7:0]). ovf/unf are still reported.

## Structure
- `fpmul_pkg`: state enum, `FP_BIAS`=127, field widths (`EXP_W`=8, `FRAC_W`=23), canonical NaN constant.
- One combinational sub-module `fpmul_pack`: takes sign, 10-bit exponent and 25-bit product; returns z, ovf and unf. It also contains the special-case overrides when `FPMUL_SPECIAL_EN` is defined.

## Test plan
- 0x40000000 × 0x40400000 (2.0×3.0) → z=0x40C00000, flags 0, exactly one 1-cycle mul_start pulse.
- 0x3FC00000 × 0x3FC00000 (1.5×1.5) → z=0x40100000, exercising the mul_result[24]=1 path.
- 0x7F000000 × 0x7F000000 → ovf=1. With the macro z=0x7F800000; without it z carries the wrapped exponent.
- With the macro: 0x00000000 × 0x40400000 → z=0x00000000, no mul_start, latency 2.
- out_ready held low for 10 cycles after out_valid → z stable, in_ready=0, in_valid pulses ignored. Release → IDLE next cycle.
- mul_done stuck high → err=1, z=0x7FC00000 after MUL_TIMEOUT cycles. Separately, rst_n pulsed low during WAIT → all outputs at reset values and in_ready=1 after release.
